// File: rtl/userio_osd_cmd_pkg.sv
// Shared OSD command definitions: FSM state encodings, command opcodes and
// the opcode-to-next-state decode used by the command front end.
package userio_osd_cmd_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WR_BUF  = 3'd1,
    ST_WR_CFG  = 3'd2,
    ST_RD_STAT = 3'd3,
    ST_IGNORE  = 3'd4
  } state_t;

  // Command opcodes live in the upper nibble of the first byte after chip select.
  localparam logic [3:0] OP_WR_BUF = 4'h2;
  localparam logic [3:0] OP_DISP   = 4'h4;
  localparam logic [3:0] OP_HILITE = 4'h5;
  localparam logic [3:0] OP_CFG    = 4'h8;
  localparam logic [3:0] OP_STATUS = 4'hC;

  // Status read is the single full byte 0xC0; any other 0xCx is a no-op.
  function automatic state_t cmd_target(input logic [7:0] b);
    case (b[7:4])
      OP_WR_BUF: return ST_WR_BUF;
      OP_CFG:    return ST_WR_CFG;
      OP_STATUS: return (b[3:0] == 4'h0) ? ST_RD_STAT : ST_IGNORE;
      default:   return ST_IGNORE;
    endcase
  endfunction

endpackage

// File: rtl/userio_osd_cmd.sv
// OSD command decoder: turns the SPI byte stream into OSD buffer writes,
// configuration writes, display control and a streamed status readback.
module userio_osd_cmd
  import userio_osd_cmd_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        rx,
  input  logic        cmd,
  input  logic [7:0]  din,
  output logic [7:0]  spi_in,
  output logic        buf_wr,
  output logic [11:0] buf_addr,
  output logic [7:0]  buf_dat,
  output logic        osd_enable,
  output logic [3:0]  highlight,
  output logic        cfg_wr,
  output logic [2:0]  cfg_idx,
  output logic [7:0]  cfg_dat,
  input  logic [7:0]  status
);

  state_t      state, state_next;
  logic        rx_d;
  logic        stb;
  logic [3:0]  row;
  logic [7:0]  col;
  logic        ld_row, ld_en, ld_hl, ld_idx;
  logic        do_buf, do_cfg;
  logic [7:0]  spi_next;

  assign stb = rx ^ rx_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_next;
  end

  // NOTE: every signal written here gets a default first, so no path
  // through the block can leave one unassigned and infer a latch.
  always_comb begin
    state_next = state;
    ld_row     = 1'b0;
    ld_en      = 1'b0;
    ld_hl      = 1'b0;
    ld_idx     = 1'b0;
    do_buf     = 1'b0;
    do_cfg     = 1'b0;
    if (stb && cmd) begin
      // A command byte always wins, even mid-stream, and never writes.
      state_next = cmd_target(din);
      case (din[7:4])
        OP_WR_BUF: ld_row = 1'b1;
        OP_DISP:   ld_en  = 1'b1;
        OP_HILITE: ld_hl  = 1'b1;
        OP_CFG:    ld_idx = 1'b1;
        default:   ;
      endcase
    end else if (stb) begin
      case (state)
        ST_WR_BUF: do_buf = 1'b1;
        ST_WR_CFG: do_cfg = 1'b1;
        default:   ;
      endcase
    end
  end

  // spi_in is non-zero only while streaming status; a fresh sample is taken
  // on every byte so the host sees live status on repeated reads.
  always_comb begin
    spi_next = 8'h00;
    if (state_next == ST_RD_STAT) spi_next = stb ? status : spi_in;
  end

  // NOTE: state and outputs use non-blocking assignments so every register
  // samples pre-edge values, e.g. buf_addr captures col before it increments.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_d       <= 1'b0;
      row        <= '0;
      col        <= '0;
      buf_wr     <= 1'b0;
      buf_addr   <= '0;
      buf_dat    <= '0;
      osd_enable <= 1'b0;
      highlight  <= '0;
      cfg_wr     <= 1'b0;
      cfg_idx    <= '0;
      cfg_dat    <= '0;
      spi_in     <= 8'h00;
    end else begin
      rx_d   <= rx;
      buf_wr <= 1'b0;
      cfg_wr <= 1'b0;
      spi_in <= spi_next;
      if (ld_row) begin
        row <= din[3:0];
        col <= '0;
      end
      if (ld_en)  osd_enable <= din[0];
      if (ld_hl)  highlight  <= din[3:0];
      if (ld_idx) cfg_idx    <= din[2:0];
      if (do_buf) begin
        buf_wr   <= 1'b1;
        buf_addr <= {row, col};
        buf_dat  <= din;
        col      <= col + 8'd1;  // wraps 255 -> 0, row untouched
      end
      if (do_cfg) begin
        cfg_wr  <= 1'b1;
        cfg_dat <= din;
      end
    end
  end

endmodule
